// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line engine feeding the back buffer write port.
// Accepts one endpoint/colour command at a time and emits one pixel write per
// non-held cycle at column-major address y + V_RES*x.
// Optional feature macro: LINE_CLIP_EN -- off-screen pixels are stepped
// through without asserting we; cycle count is unchanged.
module line_rasterizer #(
    parameter  int NUMBER_COLORS = 9,
    parameter  int H_RES         = 320,
    parameter  int V_RES         = 240,
    localparam int CW            = $clog2(NUMBER_COLORS) + 1,
    localparam int AW            = $clog2(H_RES * V_RES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [8:0]    x0,
    input  logic [8:0]    x1,
    input  logic [7:0]    y0,
    input  logic [7:0]    y1,
    input  logic [CW-1:0] color,
    input  logic          hold,
    output logic          ready,
    output logic [AW-1:0] waddr,
    output logic [CW-1:0] din,
    output logic          we,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;

    // Latched command
    logic [8:0]    x0_q, x1_q;
    logic [7:0]    y0_q, y1_q;
    logic [CW-1:0] color_q;

    // Stepping state
    logic [8:0]         cx_q, dx_q;
    logic [7:0]         cy_q;
    logic signed [8:0]  dy_q;
    logic               sx_q, sy_q;     // 1 = step in the negative direction
    logic signed [10:0] err_q;

    // Registered outputs
    logic          ready_q, we_q, done_q;
    logic [AW-1:0] waddr_q;
    logic [CW-1:0] din_q;

    // Next-state helpers
    logic [8:0]         dx_d;
    logic [7:0]         ady_d;
    logic signed [8:0]  dy_d;
    logic               sx_d, sy_d;
    logic signed [10:0] err_init_d;
    logic signed [11:0] e2_d;
    logic               step_x_d, step_y_d, at_end_d, on_screen_d;
    logic signed [10:0] err_d;
    logic [8:0]         cx_d;
    logic [7:0]         cy_d;
    logic [AW-1:0]      waddr_d;

    assign ready = ready_q;
    assign we    = we_q;
    assign done  = done_q;
    assign waddr = waddr_q;
    assign din   = din_q;

    // Setup values from the latched endpoints and the per-pixel Bresenham step
    always_comb begin
        dx_d       = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady_d      = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        dy_d       = 9'sd0 - $signed({1'b0, ady_d});
        sx_d       = (x1_q < x0_q);
        sy_d       = (y1_q < y0_q);
        err_init_d = $signed({2'b00, dx_d}) + $signed({{2{dy_d[8]}}, dy_d});

        e2_d     = $signed({err_q, 1'b0});
        step_x_d = (e2_d >= $signed({{3{dy_q[8]}}, dy_q}));
        step_y_d = (e2_d <= $signed({3'b000, dx_q}));

        err_d = err_q;
        if (step_x_d) begin
            err_d = err_d + $signed({{2{dy_q[8]}}, dy_q});
        end
        if (step_y_d) begin
            err_d = err_d + $signed({2'b00, dx_q});
        end

        cx_d = cx_q;
        if (step_x_d) begin
            cx_d = sx_q ? (cx_q - 9'd1) : (cx_q + 9'd1);
        end
        cy_d = cy_q;
        if (step_y_d) begin
            cy_d = sy_q ? (cy_q - 8'd1) : (cy_q + 8'd1);
        end

        at_end_d = (cx_q == x1_q) && (cy_q == y1_q);
        // Product is truncated to the address width on purpose
        waddr_d  = AW'(cy_q) + AW'(V_RES) * AW'(cx_q);

`ifdef LINE_CLIP_EN
        on_screen_d = (32'(cx_q) < 32'(H_RES)) && (32'(cy_q) < 32'(V_RES));
`else
        on_screen_d = 1'b1;
`endif
    end

    // Control FSM with registered outputs; ready returns one cycle after done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            err_q   <= '0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (ready_q && start) begin
                        x0_q    <= x0;
                        x1_q    <= x1;
                        y0_q    <= y0;
                        y1_q    <= y1;
                        color_q <= color;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    dx_q    <= dx_d;
                    dy_q    <= dy_d;
                    sx_q    <= sx_d;
                    sy_q    <= sy_d;
                    err_q   <= err_init_d;
                    cx_q    <= x0_q;
                    cy_q    <= y0_q;
                    state_q <= DRAW;
                end
                DRAW: begin
                    if (hold) begin
                        we_q <= 1'b0;
                    end else begin
                        we_q    <= on_screen_d;
                        waddr_q <= waddr_d;
                        din_q   <= color_q;
                        if (at_end_d) begin
                            state_q <= DONE;
                        end else begin
                            cx_q  <= cx_d;
                            cy_q  <= cy_d;
                            err_q <= err_d;
                        end
                    end
                end
                DONE: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Hardware Bresenham line engine that sits directly upstream of the back buffer. It accepts one line command at a time: two endpoints plus a colour id. It then emits one pixel write per cycle on the back buffer's write port (`waddr`, `din`, `we`). This offloads per-pixel address generation from the processor, which only issues endpoint commands and watches `done` before requesting a swap.

## Interface
- `NUMBER_COLORS`, 9, palette size; colour width CW = $clog2(NUMBER_COLORS)+1, matching back buffer `din`
- `H_RES`, 320, screen width in pixels
- `V_RES`, 240, screen height in pixels
- `clk`  in  1  system clock, same clock as back buffer
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  command valid; accepted only when `ready`=1
- `x0`, `x1`  in  9 each  start and end column
- `y0`, `y1`  in  8 each  start and end row
- `color`  in  CW  colour id, written to every pixel of the line
- `hold`  in  1  back-buffer port busy; freezes drawing
- `ready`  out  1  idle, able to accept a command
- `waddr`  out  $clog2(H_RES*V_RES)  back buffer write address, `y + V_RES*x` (column-major)
- `din`  out  CW  pixel colour
- `we`  out  1  back buffer write enable
- `done`  out  1  one-cycle pulse when a line completes

## Operation
- FSM states: IDLE, SETUP, DRAW, DONE.
  - IDLE → SETUP on `start`.
  - SETUP → DRAW unconditionally.
  - DRAW → DONE after the end pixel is emitted.
  - DONE → IDLE unconditionally.
- IDLE: `ready`=1. When `start`=1, latch x0/y0/x1/y1/color; the command registers are now frozen.
- SETUP computes the stepping values:
  - dx = |x1-x0| (unsigned, 9b)
  - dy = -|y1-y0| (signed, 9b)
  - sx = +1 or -1, sy = +1 or -1
  - err = dx+dy (signed, 11b)
  - Current position (cx, cy) = (x0, y0).
- DRAW, on each cycle with `hold`=0:
  - Register `we`=1, `waddr`=cy + V_RES*cx, `din`=color.
  - If (cx, cy) = (x1, y1), go to DONE.
  - Otherwise e2 = 2*err (signed, 12b).
  - If e2 ≥ dy: err += dy, cx += sx.
  - If e2 ≤ dx: err += dx, cy += sy.
  - Both updates may occur in the same cycle (diagonal step).
- DRAW with `hold`=1: `we`=0, and position, err and state are unchanged. The pending pixel is emitted after `hold` drops. No pixel is lost or duplicated.
- Pixel count per line = max(dx, |dy|)+1. A zero-length line (x0=x1, y0=y1) writes exactly 1 pixel.
- DONE: `done`=1 for one cycle, `we`=0, `ready`=0.
- `start` outside IDLE is ignored; no queueing.
- `resetn` low at any time, including mid-line: immediately go to IDLE. The line is abandoned with no further writes.
- Reset values: `ready`=1, `we`=0, `done`=0, `waddr`=0, `din`=0. All internal registers are 0.

## Timing
- `waddr`, `din`, `we`, `done` and `ready` are registered outputs.
- `start` is sampled at edge E0. SETUP occupies E0→E1. The first `we`=1 is visible after E2, i.e. 2 cycles after acceptance.
- With no `hold`, an N-pixel line gives N consecutive `we` cycles, then `done` in the next cycle, then `ready` the cycle after.
- Total command-to-ready = N+3 cycles, plus one cycle per `hold` cycle sampled in DRAW.
- `hold` affects the same-edge register update. `we` drops in the cycle after `hold` is sampled high.
- Back buffer write is synchronous: it writes on the edge after `we`=1 is presented.

## Configuration
- `LINE_CLIP_EN` defined:
  - Pixels with cx ≥ H_RES or cy ≥ V_RES are stepped through but not written (`we`=0 for that cycle).
  - Cycle count is unchanged.
- `LINE_CLIP_EN` undefined:
  - Every pixel asserts `we`. The caller guarantees endpoints are on-screen.
  - Off-screen addresses are truncated to `waddr` width; behaviour is undefined at the back buffer.

## Test plan
- Horizontal line (0,0)→(3,0), color 2: `we` on 4 consecutive cycles, `waddr` = 0, 240, 480, 720, `din`=2, then `done` for 1 cycle.
- Vertical reversed line (5,10)→(5,7): `waddr` = 1210, 1209, 1208, 1207; `ready` returns 1 on cycle 7 after accept.
- Diagonal (0,0)→(2,2) and steep (0,0)→(1,3):
  - Diagonal: `waddr` = 0, 241, 482.
  - Steep: (0,0), (0,1), (1,2), (1,3), i.e. `waddr` = 0, 1, 242, 243.
- Single point (319,239): exactly one write at 76799, then `done`. A second `start` asserted during DRAW is ignored.
- Hold: assert `hold` for 3 cycles mid-line on (0,0)→(7,0):
  - Exactly 8 writes total, no duplicate addresses.
  - `done` is 3 cycles later than without `hold`.
- Reset and clipping:
  - `resetn` low after 2 pixels of (0,0)→(9,0): outputs return to reset values immediately and no further `we`.
  - With `LINE_CLIP_EN`, (318,0)→(321,0): writes only at 76320 and 76560; 4 DRAW cycles.
